// File: rtl/cond_accum_monitor.sv
// Conditional accumulator with a step counter, threshold comparators and a
// debounced sticky HIT monitor FSM.
module cond_accum_monitor #(
  parameter int WIDTH    = 2,
  parameter int CNT_W    = 2,
  parameter int INIT     = 1,
  parameter int THRESH   = 2,
  parameter int HOLD_CYC = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] add,
  output logic [WIDTH-1:0] x_out,
  output logic [CNT_W-1:0] step,
  output logic             z_gt,
  output logic             z_eq,
  output logic             z_hit
);

  localparam int HC_W = $clog2(HOLD_CYC + 1);
  localparam logic [WIDTH-1:0] INIT_W = WIDTH'(INIT);
  localparam logic [HC_W-1:0]  HOLD_W = HC_W'(HOLD_CYC);
  // A threshold at or beyond the largest x value can never be exceeded.
  localparam bit               THRESH_HI = (THRESH >= (2 ** WIDTH) - 1);
  localparam bit               THRESH_EQ_OK = (THRESH < (2 ** WIDTH));
  localparam logic [WIDTH-1:0] THRESH_W = WIDTH'(THRESH);

  localparam logic [1:0] MODE_MATCH  = 2'b00;
  localparam logic [1:0] MODE_ALWAYS = 2'b01;
  localparam logic [1:0] MODE_SAT    = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [1:0] {WATCH = 2'd0, PEND = 2'd1, HIT = 2'd2} state_t;

  logic [WIDTH-1:0] x_q, x_d;
  logic [CNT_W-1:0] step_q;
  logic [HC_W-1:0]  hc_q, hc_d;
  state_t           state_q, state_d;
  logic             advance;

  function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  endfunction

  assign advance = en && !clr;

  always_comb begin
    x_d = x_q;
    unique case (mode)
      MODE_MATCH:  if (add == x_q) x_d = x_q + add;
      MODE_ALWAYS: x_d = x_q + add;
      MODE_SAT:    if (add == x_q) x_d = sat_add(x_q, add);
      MODE_HOLD:   x_d = x_q;
      default:     x_d = x_q;
    endcase
  end

  // Datapath registers: x and the enabled-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q    <= INIT_W;
      step_q <= '0;
    end else if (clr) begin
      x_q    <= INIT_W;
      step_q <= '0;
    end else if (en) begin
      x_q    <= x_d;
      step_q <= step_q + 1'b1;
    end
  end

  assign z_gt  = !THRESH_HI && (x_q > THRESH_W);
  assign z_eq  = THRESH_EQ_OK && (x_q == THRESH_W);
  assign x_out = x_q;
  assign step  = step_q;

  // Monitor FSM: state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= WATCH;
      hc_q    <= '0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
    end
  end

  // Monitor FSM: next state, judged on z_gt of the current x
  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    if (clr) begin
      state_d = WATCH;
      hc_d    = '0;
    end else if (advance) begin
      unique case (state_q)
        WATCH: begin
          if (z_gt) begin
            if (HOLD_CYC == 1) begin
              state_d = HIT;
              hc_d    = '0;
            end else begin
              state_d = PEND;
              hc_d    = HC_W'(1);
            end
          end
        end
        PEND: begin
          if (!z_gt) begin
            state_d = WATCH;
            hc_d    = '0;
          end else if (hc_q + HC_W'(1) == HOLD_W) begin
            state_d = HIT;
            hc_d    = '0;
          end else begin
            hc_d = hc_q + HC_W'(1);
          end
        end
        HIT:     state_d = HIT;
        default: begin
          state_d = WATCH;
          hc_d    = '0;
        end
      endcase
    end
  end

  // Monitor FSM: outputs
  always_comb begin
    z_hit = (state_q == HIT);
  end

endmodule

// File: tb/tb_cond_accum_monitor.sv
// Directed bench for cond_accum_monitor at WIDTH=2, CNT_W=2, INIT=1,
// THRESH=2, HOLD_CYC=2 with hand-computed expectations.
module tb_cond_accum_monitor;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic [1:0] mode;
  logic [1:0] add;
  logic [1:0] x_out;
  logic [1:0] step;
  logic       z_gt;
  logic       z_eq;
  logic       z_hit;

  int vectors;
  int miscompares;

  localparam logic [1:0] M_MATCH  = 2'b00;
  localparam logic [1:0] M_ALWAYS = 2'b01;
  localparam logic [1:0] M_SAT    = 2'b10;
  localparam logic [1:0] M_HOLD   = 2'b11;

  cond_accum_monitor #(
    .WIDTH(2), .CNT_W(2), .INIT(1), .THRESH(2), .HOLD_CYC(2)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .mode(mode), .add(add),
    .x_out(x_out), .step(step), .z_gt(z_gt), .z_eq(z_eq), .z_hit(z_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] ex, input logic [1:0] es,
                         input logic eg, input logic ee, input logic eh);
    chk({tag, ".x"},    32'(x_out), 32'(ex));
    chk({tag, ".step"}, 32'(step),  32'(es));
    chk({tag, ".gt"},   32'(z_gt),  32'(eg));
    chk({tag, ".eq"},   32'(z_eq),  32'(ee));
    chk({tag, ".hit"},  32'(z_hit), 32'(eh));
  endtask

  // Advance one clock and settle just after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b0; en = 1'b0; clr = 1'b0; mode = M_MATCH; add = 2'd0;
    #12;
    chk_all("reset", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();

    // MATCH: 1+1 -> 2, then add=1 no longer matches x
    en = 1'b1; mode = M_MATCH; add = 2'd1;
    tick(); chk_all("match1", 2'd2, 2'd1, 1'b0, 1'b1, 1'b0);
    tick(); chk_all("match2", 2'd2, 2'd2, 1'b0, 1'b1, 1'b0);

    // ALWAYS: 2 -> 3 -> 0 with wrap; step wraps 3 -> 0
    mode = M_ALWAYS; add = 2'd1;
    tick(); chk_all("always1", 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("always2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);

    // SAT: 2+2 saturates at 3, 3+3 stays 3
    add = 2'd2;
    tick(); chk_all("to2", 2'd2, 2'd1, 1'b0, 1'b1, 1'b0);
    mode = M_SAT; add = 2'd2;
    tick(); chk_all("sat1", 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    add = 2'd3;
    tick(); chk_all("sat2", 2'd3, 2'd3, 1'b1, 1'b0, 1'b0);
    mode = M_SAT; add = 2'd0;
    tick(); chk_all("sat_nomatch", 2'd3, 2'd0, 1'b1, 1'b0, 1'b1);

    // clr, then debounce from WATCH: needs two z_gt edges before HIT
    clr = 1'b1;
    tick(); chk_all("clr1", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0; mode = M_ALWAYS; add = 2'd2;
    tick(); chk_all("up3", 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    mode = M_HOLD;
    tick(); chk_all("hold_pend", 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    tick(); chk_all("hold_hit", 2'd3, 2'd3, 1'b1, 1'b0, 1'b1);
    mode = M_ALWAYS; add = 2'd1;
    tick(); chk_all("hit_sticky", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);

    // en=0 freezes everything
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("freeze_hit", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    end

    // en=0 in PEND keeps hc: one more enabled z_gt cycle reaches HIT
    en = 1'b1; clr = 1'b1;
    tick(); chk_all("clr2", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0; mode = M_ALWAYS; add = 2'd2;
    tick(); chk_all("up3b", 2'd3, 2'd1, 1'b1, 1'b0, 1'b0);
    mode = M_HOLD;
    tick(); chk_all("pend_b", 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk_all("freeze_pend", 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    end
    en = 1'b1;
    tick(); chk_all("pend_resume", 2'd3, 2'd3, 1'b1, 1'b0, 1'b1);

    // async reset mid-PEND, between edges
    clr = 1'b1;
    tick();
    clr = 1'b0; mode = M_ALWAYS; add = 2'd2;
    tick();
    mode = M_HOLD;
    tick(); chk_all("pend_c", 2'd3, 2'd2, 1'b1, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk_all("async_rst", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick(); chk_all("after_rst", 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);

    // clr beats a matching MATCH update
    clr = 1'b1; mode = M_MATCH; add = 2'd1;
    tick(); chk_all("clr_wins", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0);
    clr = 1'b0;
    tick(); chk_all("match_post", 2'd2, 2'd1, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
